// File: rtl/seg_scan.sv
// Time-multiplexed 7-segment scanner: one digit per slot, dead time at the start of
// each slot, frame-coherent shadow of the display data and a frame-complete strobe.
module seg_scan #(
  parameter int NUM_DIGITS      = 6,
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLANK_TICKS     = 5000,
  parameter bit SEL_ACTIVE_HIGH = 1'b1,
  parameter bit SEG_ACTIVE_HIGH = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    en,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   seg_sel,
  output logic [7:0]              seg_led,
  output logic                    frame_done
);

  localparam int TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [TW-1:0] BLANK_LAST = (BLANK_TICKS > 0) ? TW'(BLANK_TICKS - 1) : '0;
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = SEL_ACTIVE_HIGH ? '0 : '1;
  localparam logic [7:0] LED_OFF = SEG_ACTIVE_HIGH ? 8'h00 : 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           tick_q, tick_d;
  logic [DW-1:0]           digit_q, digit_d;
  logic [4*NUM_DIGITS-1:0] data_sh_q, data_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic                    lz_sh_q, lz_sh_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]              led_q, led_d;
  logic                    fd_q, fd_d;

  logic [NUM_DIGITS-1:0]   sel_oh;
  logic [3:0]              nib;
  logic                    lz_hide;
  logic [7:0]              seg_raw;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
      default: hex7 = 7'h00;
    endcase
  endfunction

  function automatic logic [3:0] nibble_at(input logic [4*NUM_DIGITS-1:0] d,
                                           input logic [DW-1:0] idx);
    nibble_at = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == DW'(i)) nibble_at = d[4*i +: 4];
      else nibble_at = nibble_at;
    end
  endfunction

  // True when nibble idx and every more-significant nibble are zero.
  function automatic logic upper_zero(input logic [4*NUM_DIGITS-1:0] d,
                                      input logic [DW-1:0] idx);
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (DW'(i) >= idx && d[4*i +: 4] != 4'h0) upper_zero = 1'b0;
      else upper_zero = upper_zero;
    end
  endfunction

  // Current digit's one-hot select and active-high segment pattern
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_oh[i] = (digit_q == DW'(i));
    end
    nib     = nibble_at(data_sh_q, digit_q);
    lz_hide = lz_sh_q && (digit_q != '0) && upper_zero(data_sh_q, digit_q);
    seg_raw = {|(sel_oh & dp_sh_q), lz_hide ? 7'h00 : hex7(nib)};
  end

  // Scan sequencer; outputs are computed from the present state and registered
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    digit_d   = digit_q;
    data_sh_d = data_sh_q;
    dp_sh_d   = dp_sh_q;
    lz_sh_d   = lz_sh_q;
    sel_d     = SEL_OFF;
    led_d     = LED_OFF;
    fd_d      = 1'b0;
    if (!en) begin
      state_d = IDLE;
      tick_d  = '0;
      digit_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          tick_d    = '0;
          digit_d   = '0;
          data_sh_d = data;
          dp_sh_d   = dp;
          lz_sh_d   = lz_blank;
          state_d   = (BLANK_TICKS == 0) ? DRIVE : BLANK;
        end
        BLANK: begin
          tick_d = tick_q + TW'(1);
          if (tick_q == BLANK_LAST) state_d = DRIVE;
          else state_d = BLANK;
        end
        DRIVE: begin
          sel_d = SEL_ACTIVE_HIGH ? sel_oh : ~sel_oh;
          led_d = SEG_ACTIVE_HIGH ? seg_raw : ~seg_raw;
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            state_d = (BLANK_TICKS == 0) ? DRIVE : BLANK;
            // Shadow reloads only as the scan wraps back into digit 0.
            if (digit_q == DIGIT_LAST) begin
              fd_d      = 1'b1;
              digit_d   = '0;
              data_sh_d = data;
              dp_sh_d   = dp;
              lz_sh_d   = lz_blank;
            end else begin
              digit_d = digit_q + DW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          tick_d  = '0;
          digit_d = '0;
        end
      endcase
    end
  end

  // State, shadow and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      digit_q   <= '0;
      data_sh_q <= '0;
      dp_sh_q   <= '0;
      lz_sh_q   <= 1'b0;
      sel_q     <= SEL_OFF;
      led_q     <= LED_OFF;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      digit_q   <= digit_d;
      data_sh_q <= data_sh_d;
      dp_sh_q   <= dp_sh_d;
      lz_sh_q   <= lz_sh_d;
      sel_q     <= sel_d;
      led_q     <= led_d;
      fd_q      <= fd_d;
    end
  end

  assign seg_sel    = sel_q;
  assign seg_led    = led_q;
  assign frame_done = fd_q;

endmodule
